// File: rtl/apb_crypto_regs.sv
// APB completer for the crypto accelerator register map; define KEY_READ_MASK_EN to make KEY0..KEY3 write-only.
// pready two cycles after the SETUP phase plus WAIT_CYCLES wait states; the only backpressure is APB wait states.
module apb_crypto_regs #(
  parameter logic [19:0] BASE_ADDR   = 20'h00000,
  parameter int          WAIT_CYCLES = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        psel,
  input  logic        penable,
  input  logic        pwrite,
  input  logic [1:0]  pstrb,
  input  logic [19:0] paddr,
  input  logic [15:0] pwdata,
  output logic [15:0] prdata,
  output logic        pready,
  output logic        pslverr,
  input  logic        core_busy,
  input  logic        core_done,
  input  logic [15:0] core_result,
  output logic        ctrl_start,
  output logic [63:0] key,
  output logic [15:0] data_in,
  output logic        irq
);

  typedef enum logic [1:0] {ST_IDLE, ST_SETUP, ST_ACCESS} state_t;

  typedef struct packed {
    logic [19:0] addr;
    logic        write;
    logic [1:0]  strb;
    logic [15:0] wdata;
  } apb_req_t;

  localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

  state_t          state, state_nxt;
  apb_req_t        req;
  logic [3:0]      wait_cnt;
  logic            pready_q;
  logic            ctrl_start_q;
  logic            irq_en;
  logic            done;
  logic [3:0][15:0] key_q;
  logic [15:0]     din_q;
  logic [15:0]     dout_q;

  logic [20:0]     off_full;
  logic [3:0]      off;
  logic            in_win;
  logic            acc_err;
  logic            complete;
  logic            do_write;
  logic [15:0]     rd_val;

  function automatic logic [15:0] merge(input logic [15:0] old_v, input logic [15:0] new_v,
                                        input logic [1:0] strb);
    return {strb[1] ? new_v[15:8] : old_v[15:8], strb[0] ? new_v[7:0] : old_v[7:0]};
  endfunction

  // A 21-bit difference makes addresses below BASE_ADDR land outside the window too.
  assign off_full = {1'b0, req.addr} - {1'b0, BASE_ADDR};
  assign off      = off_full[3:0];
  assign in_win   = (off_full[20:4] == 17'd0);

  always_comb begin
    acc_err = 1'b0;
    if (!in_win || req.addr[0]) begin
      acc_err = 1'b1;
    end else if (req.write && (off == 4'hE)) begin
      acc_err = 1'b1;
    end else if (req.write && (off == 4'h0) && req.strb[0] && req.wdata[0] && core_busy) begin
      acc_err = 1'b1;
    end
  end

  always_comb begin
    rd_val = 16'h0000;
    case (off)
      4'h0: rd_val = {14'd0, irq_en, 1'b0};
      4'h2: rd_val = {14'd0, done, core_busy};
`ifdef KEY_READ_MASK_EN
      4'h4, 4'h6, 4'h8, 4'hA: rd_val = 16'h0000;
`else
      4'h4: rd_val = key_q[0];
      4'h6: rd_val = key_q[1];
      4'h8: rd_val = key_q[2];
      4'hA: rd_val = key_q[3];
`endif
      4'hC: rd_val = din_q;
      4'hE: rd_val = dout_q;
      default: rd_val = 16'h0000;
    endcase
  end

  assign complete = (state == ST_ACCESS) && pready_q && psel && penable;
  assign do_write = complete && req.write && !acc_err;

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:   if (psel && !penable) state_nxt = ST_SETUP;
      ST_SETUP:  state_nxt = psel ? ST_ACCESS : ST_IDLE;
      ST_ACCESS: if (!psel || pready_q) state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= ST_IDLE;
      req          <= '0;
      wait_cnt     <= 4'd0;
      pready_q     <= 1'b0;
      ctrl_start_q <= 1'b0;
      irq_en       <= 1'b0;
      done         <= 1'b0;
      key_q        <= '0;
      din_q        <= 16'h0000;
      dout_q       <= 16'h0000;
    end else begin
      state        <= state_nxt;
      ctrl_start_q <= 1'b0;

      case (state)
        ST_SETUP: begin
          req      <= '{addr: paddr, write: pwrite, strb: pstrb, wdata: pwdata};
          wait_cnt <= WAIT_INIT;
          pready_q <= psel && (WAIT_INIT == 4'd0);
        end
        ST_ACCESS: begin
          if (pready_q || !psel) begin
            pready_q <= 1'b0;
            wait_cnt <= 4'd0;
          end else begin
            wait_cnt <= wait_cnt - 4'd1;
            pready_q <= (wait_cnt == 4'd1);
          end
        end
        default: pready_q <= 1'b0;
      endcase

      // A done pulse in the same cycle as a W1C leaves DONE set.
      if (core_done) begin
        done   <= 1'b1;
        dout_q <= core_result;
      end else if (do_write && (off == 4'h2) && req.strb[0] && req.wdata[1]) begin
        done <= 1'b0;
      end

      if (do_write) begin
        case (off)
          4'h0: begin
            if (req.strb[0]) begin
              irq_en       <= req.wdata[1];
              ctrl_start_q <= req.wdata[0];
            end
          end
          4'h4: key_q[0] <= merge(key_q[0], req.wdata, req.strb);
          4'h6: key_q[1] <= merge(key_q[1], req.wdata, req.strb);
          4'h8: key_q[2] <= merge(key_q[2], req.wdata, req.strb);
          4'hA: key_q[3] <= merge(key_q[3], req.wdata, req.strb);
          4'hC: din_q    <= merge(din_q, req.wdata, req.strb);
          default: ;
        endcase
      end
    end
  end

  assign pready     = pready_q;
  assign pslverr    = pready_q && acc_err;
  assign prdata     = (pready_q && !req.write && !acc_err) ? rd_val : 16'h0000;
  assign ctrl_start = ctrl_start_q;
  assign key        = key_q;
  assign data_in    = din_q;
  assign irq        = done && irq_en;

endmodule

// File: tb/tb_apb_crypto_regs.sv
// Bench for apb_crypto_regs: two instances (WAIT_CYCLES=1 and 3) sharing the bus, checked against a register-array model.
module tb_apb_crypto_regs;

  localparam logic [19:0] BASE = 20'h00000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, psel, penable, pwrite;
  logic [1:0]  pstrb;
  logic [19:0] paddr;
  logic [15:0] pwdata;
  logic        core_busy, core_done;
  logic [15:0] core_result;
  int          tgt;
  logic        psel_a, psel_b;

  logic [15:0] prdata_v [2];
  logic        pready_v [2];
  logic        pslverr_v [2];
  logic        start_v [2];
  logic [63:0] key_v [2];
  logic [15:0] din_v [2];
  logic        irq_v [2];

  assign psel_a = psel && (tgt == 0);
  assign psel_b = psel && (tgt == 1);

  apb_crypto_regs #(.BASE_ADDR(BASE), .WAIT_CYCLES(1)) u_dut_a (
    .clk(clk), .reset(reset), .psel(psel_a), .penable(penable), .pwrite(pwrite),
    .pstrb(pstrb), .paddr(paddr), .pwdata(pwdata), .prdata(prdata_v[0]),
    .pready(pready_v[0]), .pslverr(pslverr_v[0]), .core_busy(core_busy),
    .core_done(core_done), .core_result(core_result), .ctrl_start(start_v[0]),
    .key(key_v[0]), .data_in(din_v[0]), .irq(irq_v[0]));

  apb_crypto_regs #(.BASE_ADDR(BASE), .WAIT_CYCLES(3)) u_dut_b (
    .clk(clk), .reset(reset), .psel(psel_b), .penable(penable), .pwrite(pwrite),
    .pstrb(pstrb), .paddr(paddr), .pwdata(pwdata), .prdata(prdata_v[1]),
    .pready(pready_v[1]), .pslverr(pslverr_v[1]), .core_busy(core_busy),
    .core_done(core_done), .core_result(core_result), .ctrl_start(start_v[1]),
    .key(key_v[1]), .data_in(din_v[1]), .irq(irq_v[1]));

  int n_chk = 0;
  int n_fail = 0;
  logic chk_en = 1'b0;

  // Model: one 16-bit word per register slot (offset/2); word 1 holds only DONE at bit 1.
  logic [15:0] m_word [2][8];
  logic        m_start [2];
  logic        pend_vld = 1'b0;
  int          pend_d;
  logic [19:0] pend_a;
  logic [1:0]  pend_s;
  logic [15:0] pend_w;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic exp_err(input logic wr, input logic [19:0] a, input logic [1:0] s,
                                   input logic [15:0] w);
    int off = int'(a) - int'(BASE);
    if (off < 0 || off > 15 || a[0]) return 1'b1;
    if (wr && off == 14) return 1'b1;
    if (wr && off == 0 && s[0] && w[0] && core_busy) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [15:0] exp_rd(input int d, input logic [19:0] a);
    int i = (int'(a) - int'(BASE)) / 2;
    if (i == 1) return m_word[d][1] | {15'd0, core_busy};
`ifdef KEY_READ_MASK_EN
    if (i >= 2 && i <= 5) return 16'h0000;
`endif
    return m_word[d][i];
  endfunction

  function automatic void model_apply(input int d, input logic [19:0] a, input logic [1:0] s,
                                      input logic [15:0] w);
    int i = (int'(a) - int'(BASE)) / 2;
    logic [15:0] bm = {{8{s[1]}}, {8{s[0]}}};
    if (i == 0) begin
      m_word[d][0] = (m_word[d][0] & ~(bm & 16'h0002)) | (w & bm & 16'h0002);
      m_start[d]   = bm[0] & w[0];
    end else if (i == 1) begin
      if (bm[1] & w[1]) m_word[d][1] = 16'h0000;
    end else begin
      m_word[d][i] = (m_word[d][i] & ~bm) | (w & bm);
    end
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      for (int d = 0; d < 2; d++) begin
        for (int i = 0; i < 8; i++) m_word[d][i] = 16'h0000;
        m_start[d] = 1'b0;
      end
      pend_vld = 1'b0;
    end else begin
      for (int d = 0; d < 2; d++) m_start[d] = 1'b0;
      if (pend_vld) begin
        model_apply(pend_d, pend_a, pend_s, pend_w);
        pend_vld = 1'b0;
      end
      if (core_done) begin
        for (int d = 0; d < 2; d++) begin
          m_word[d][1] = m_word[d][1] | 16'h0002;
          m_word[d][7] = core_result;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      for (int d = 0; d < 2; d++) begin
        if (!pready_v[d]) begin
          check("idle_prdata", {48'd0, prdata_v[d]}, 64'd0);
          check("idle_pslverr", {63'd0, pslverr_v[d]}, 64'd0);
        end
        if (d != tgt) check("other_pready", {63'd0, pready_v[d]}, 64'd0);
        check("key", key_v[d], {m_word[d][5], m_word[d][4], m_word[d][3], m_word[d][2]});
        check("data_in", {48'd0, din_v[d]}, {48'd0, m_word[d][6]});
        check("irq", {63'd0, irq_v[d]}, {63'd0, m_word[d][1][1] & m_word[d][0][1]});
        check("ctrl_start", {63'd0, start_v[d]}, {63'd0, m_start[d]});
      end
    end
  end

  task automatic apb(input int d, input logic wr, input logic [19:0] a, input logic [1:0] s,
                     input logic [15:0] w, input logic lit_err, input logic [15:0] lit_rd,
                     input logic cd, input logic [15:0] cr, input string nm);
    int n;
    logic me;
    logic [15:0] mr;
    tgt = d; psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = a; pstrb = s; pwdata = w;
    @(posedge clk); #1;
    penable = 1'b1;
    @(negedge clk); n = 1;
    while (!pready_v[d] && n < 20) begin
      @(negedge clk); n++;
    end
    if (!pready_v[d]) begin
      n_chk++; n_fail++;
      $display("FAIL %s_timeout: no pready within %0d cycles", nm, n);
      psel = 1'b0; penable = 1'b0;
      @(negedge clk);
      return;
    end
    check({nm, "_latency"}, 64'(n), (d == 0) ? 64'd3 : 64'd5);
    me = exp_err(wr, a, s, w);
    mr = (me || wr) ? 16'h0000 : exp_rd(d, a);
    check({nm, "_err_model"}, {63'd0, pslverr_v[d]}, {63'd0, me});
    check({nm, "_err_lit"}, {63'd0, pslverr_v[d]}, {63'd0, lit_err});
    if (!wr) begin
      check({nm, "_rd_model"}, {48'd0, prdata_v[d]}, {48'd0, mr});
      check({nm, "_rd_lit"}, {48'd0, prdata_v[d]}, {48'd0, lit_rd});
    end
    if (wr && !me) begin
      pend_d = d; pend_a = a; pend_s = s; pend_w = w; pend_vld = 1'b1;
    end
    if (cd) begin
      core_done = 1'b1; core_result = cr;
    end
    @(posedge clk); #1;
    psel = 1'b0; penable = 1'b0; core_done = 1'b0;
    @(negedge clk);
    check({nm, "_pready_one_cycle"}, {63'd0, pready_v[d]}, 64'd0);
  endtask

  task automatic core_pulse(input logic [15:0] r);
    core_done = 1'b1; core_result = r;
    @(negedge clk);
    core_done = 1'b0;
    @(negedge clk);
  endtask

  logic [15:0] key0_lit, key2_lit, key3_lit;

  initial begin
`ifdef KEY_READ_MASK_EN
    key0_lit = 16'h0000; key2_lit = 16'h0000; key3_lit = 16'h0000;
`else
    key0_lit = 16'hBEEF; key2_lit = 16'hAB00; key3_lit = 16'hCAFE;
`endif
    reset = 1'b1; psel = 1'b0; penable = 1'b0; pwrite = 1'b0; pstrb = 2'b00;
    paddr = 20'h0; pwdata = 16'h0; core_busy = 1'b0; core_done = 1'b0;
    core_result = 16'h0; tgt = 0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("rst_pready", {63'd0, pready_v[0]}, 64'd0);
    check("rst_prdata", {48'd0, prdata_v[0]}, 64'd0);
    check("rst_pslverr", {63'd0, pslverr_v[0]}, 64'd0);
    check("rst_key", key_v[0], 64'd0);
    check("rst_din", {48'd0, din_v[0]}, 64'd0);
    check("rst_irq", {63'd0, irq_v[0]}, 64'd0);
    check("rst_start", {63'd0, start_v[0]}, 64'd0);
    chk_en = 1'b1;

    apb(0, 1, 20'h04, 2'b11, 16'hBEEF, 0, 16'h0, 0, 16'h0, "wr_key0");
    check("key0_val", {48'd0, key_v[0][15:0]}, 64'hBEEF);
    apb(0, 0, 20'h04, 2'b11, 16'h0, 0, key0_lit, 0, 16'h0, "rd_key0");

    apb(0, 1, 20'h0C, 2'b11, 16'hFFFF, 0, 16'h0, 0, 16'h0, "wr_din_ff");
    apb(0, 1, 20'h0C, 2'b01, 16'h1234, 0, 16'h0, 0, 16'h0, "wr_din_lo");
    check("din_ff34", {48'd0, din_v[0]}, 64'hFF34);
    apb(0, 1, 20'h0C, 2'b00, 16'h0000, 0, 16'h0, 0, 16'h0, "wr_din_nostrb");
    check("din_nostrb", {48'd0, din_v[0]}, 64'hFF34);
    apb(0, 1, 20'h08, 2'b10, 16'hABCD, 0, 16'h0, 0, 16'h0, "wr_key2_hi");
    apb(0, 0, 20'h08, 2'b11, 16'h0, 0, key2_lit, 0, 16'h0, "rd_key2");

    apb(0, 1, 20'h00, 2'b11, 16'h0003, 0, 16'h0, 0, 16'h0, "wr_ctrl_go");
    check("start_pulse_hi", {63'd0, start_v[0]}, 64'd1);
    @(negedge clk);
    check("start_pulse_lo", {63'd0, start_v[0]}, 64'd0);
    core_pulse(16'hA5A5);
    apb(0, 0, 20'h02, 2'b11, 16'h0, 0, 16'h0002, 0, 16'h0, "rd_status_done");
    apb(0, 0, 20'h0E, 2'b11, 16'h0, 0, 16'hA5A5, 0, 16'h0, "rd_dout");
    check("irq_set", {63'd0, irq_v[0]}, 64'd1);
    apb(0, 1, 20'h02, 2'b11, 16'h0002, 0, 16'h0, 0, 16'h0, "w1c_done");
    check("irq_clr", {63'd0, irq_v[0]}, 64'd0);

    core_busy = 1'b1;
    apb(0, 1, 20'h00, 2'b11, 16'h0001, 1, 16'h0, 0, 16'h0, "wr_ctrl_busy");
    check("no_start_busy", {63'd0, start_v[0]}, 64'd0);
    apb(0, 0, 20'h00, 2'b11, 16'h0, 0, 16'h0002, 0, 16'h0, "rd_ctrl");
    apb(0, 0, 20'h02, 2'b11, 16'h0, 0, 16'h0001, 0, 16'h0, "rd_status_busy");
    core_busy = 1'b0;
    apb(0, 0, 20'h10, 2'b11, 16'h0, 1, 16'h0, 0, 16'h0, "rd_out_of_window");
    apb(0, 0, 20'h03, 2'b11, 16'h0, 1, 16'h0, 0, 16'h0, "rd_odd_addr");
    apb(0, 1, 20'h0E, 2'b11, 16'h5555, 1, 16'h0, 0, 16'h0, "wr_dout");
    apb(0, 0, 20'h0E, 2'b11, 16'h0, 0, 16'hA5A5, 0, 16'h0, "rd_dout_kept");

    tgt = 0; psel = 1'b1; penable = 1'b1; paddr = 20'h04; pwrite = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check("no_setup_pready", {63'd0, pready_v[0]}, 64'd0);
    end
    psel = 1'b0; penable = 1'b0;
    @(negedge clk);

    apb(1, 1, 20'h06, 2'b11, 16'h1111, 0, 16'h0, 0, 16'h0, "b_wr_key1");
    tgt = 1; psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 20'h06;
    pstrb = 2'b11; pwdata = 16'h2222;
    @(posedge clk); #1;
    penable = 1'b1;
    repeat (2) begin
      @(posedge clk); #1;
    end
    psel = 1'b0; penable = 1'b0;
    repeat (6) begin
      @(negedge clk);
      check("abort_no_pready", {63'd0, pready_v[1]}, 64'd0);
    end
    check("abort_key1", {48'd0, key_v[1][31:16]}, 64'h1111);

    core_pulse(16'h0055);
    apb(0, 1, 20'h02, 2'b11, 16'h0002, 0, 16'h0, 1, 16'h0077, "w1c_vs_done");
    apb(0, 0, 20'h02, 2'b11, 16'h0, 0, 16'h0002, 0, 16'h0, "rd_done_kept");
    apb(0, 0, 20'h0E, 2'b11, 16'h0, 0, 16'h0077, 1, 16'h1111, "rd_dout_vs_done");
    apb(0, 0, 20'h0E, 2'b11, 16'h0, 0, 16'h1111, 0, 16'h0, "rd_dout_new");

    tgt = 0; psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 20'h0C;
    pstrb = 2'b11; pwdata = 16'h5A5A;
    @(posedge clk); #1;
    penable = 1'b1;
    @(posedge clk); #1;
    reset = 1'b1; psel = 1'b0; penable = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check("mid_rst_pready", {63'd0, pready_v[0]}, 64'd0);
    check("mid_rst_prdata", {48'd0, prdata_v[0]}, 64'd0);
    check("mid_rst_pslverr", {63'd0, pslverr_v[0]}, 64'd0);
    check("mid_rst_din", {48'd0, din_v[0]}, 64'd0);
    check("mid_rst_key", key_v[0], 64'd0);
    check("mid_rst_irq", {63'd0, irq_v[0]}, 64'd0);
    apb(0, 1, 20'h0A, 2'b11, 16'hCAFE, 0, 16'h0, 0, 16'h0, "post_rst_wr");
    check("post_rst_key3", {48'd0, key_v[0][63:48]}, 64'hCAFE);
    apb(0, 0, 20'h0A, 2'b11, 16'h0, 0, key3_lit, 0, 16'h0, "post_rst_rd");

    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

endmodule
